// File: rtl/video_stim_gen.sv
// rtl/video_stim_gen.sv - raster video test-pattern generator with sync and frame control
module video_stim_gen #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int CHANNEL_COUNT   = 1,
  parameter int SIZE_WIDTH      = 13,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SIZE_WIDTH-1:0]                reg_w,
  input  logic [SIZE_WIDTH-1:0]                reg_h,
  input  logic [3:0]                           reg_de_period,
  input  logic [SIZE_WIDTH-1:0]                reg_hblank,
  input  logic [SIZE_WIDTH-1:0]                reg_vblank,
  input  logic [1:0]                           reg_mode,
  input  logic [PIXEL_WIDTH-1:0]               reg_const,
  input  logic [FRAME_CNT_WIDTH-1:0]           reg_frame_count,
  input  logic                                 start,
  input  logic                                 stop,
  output logic [PIXEL_WIDTH*CHANNEL_COUNT-1:0] do_o,
  output logic                                 de_o,
  output logic                                 hs_o,
  output logic                                 vs_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t state, state_next;

  logic [SIZE_WIDTH-1:0]      lat_w, lat_h, lat_hb, lat_vb;
  logic [3:0]                 lat_p;
  logic [1:0]                 lat_mode;
  logic [PIXEL_WIDTH-1:0]     lat_const;
  logic [FRAME_CNT_WIDTH-1:0] lat_fc;

  logic [SIZE_WIDTH-1:0]      x, y, blank_cnt;
  logic [3:0]                 slot_cnt;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic                       stop_flag;

  logic [3:0]                 p_eff;
  logic [SIZE_WIDTH-1:0]      hb_eff, vb_eff;
  logic                       launch, slot_last, line_end, hb_last, vb_last, last_line, finish;
  logic [FRAME_CNT_WIDTH-1:0] frame_next;

  logic [PIXEL_WIDTH*CHANNEL_COUNT-1:0] do_n;
  logic [PIXEL_WIDTH-1:0]               pattern;
  logic                                 de_n, hs_n, vs_n, busy_n, done_n;

  // Zero periods/gaps behave as one cycle; derived end-of-segment conditions
  always_comb begin
    p_eff      = (lat_p == 4'd0) ? 4'd1 : lat_p;
    hb_eff     = (lat_hb == '0) ? SIZE_WIDTH'(1) : lat_hb;
    vb_eff     = (lat_vb == '0) ? SIZE_WIDTH'(1) : lat_vb;
    launch     = start && (reg_w != '0) && (reg_h != '0);
    slot_last  = (slot_cnt == p_eff - 4'd1);
    line_end   = slot_last && (x == lat_w - SIZE_WIDTH'(1));
    hb_last    = (blank_cnt == hb_eff - SIZE_WIDTH'(1));
    vb_last    = (blank_cnt == vb_eff - SIZE_WIDTH'(1));
    last_line  = (y == lat_h - SIZE_WIDTH'(1));
    frame_next = frame_cnt + FRAME_CNT_WIDTH'(1);
    // A stop arriving on the very last gap cycle still belongs to this frame
    finish     = vb_last && (((lat_fc != '0) && (frame_next == lat_fc)) || stop_flag || stop);
  end

  // State register plus the counters and latched configuration that travel with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      blank_cnt <= '0;
      slot_cnt  <= '0;
      frame_cnt <= '0;
      stop_flag <= 1'b0;
      lat_w     <= '0;
      lat_h     <= '0;
      lat_hb    <= '0;
      lat_vb    <= '0;
      lat_p     <= '0;
      lat_mode  <= '0;
      lat_const <= '0;
      lat_fc    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          stop_flag <= launch && stop;
          if (launch) begin
            lat_w     <= reg_w;
            lat_h     <= reg_h;
            lat_hb    <= reg_hblank;
            lat_vb    <= reg_vblank;
            lat_p     <= reg_de_period;
            lat_mode  <= reg_mode;
            lat_const <= reg_const;
            lat_fc    <= reg_frame_count;
            x         <= '0;
            y         <= '0;
            slot_cnt  <= '0;
            blank_cnt <= '0;
            frame_cnt <= '0;
          end
        end
        S_ACTIVE: begin
          stop_flag <= stop_flag || stop;
          if (slot_last) begin
            slot_cnt <= '0;
            x        <= line_end ? '0 : x + SIZE_WIDTH'(1);
          end else begin
            slot_cnt <= slot_cnt + 4'd1;
          end
        end
        S_HBLANK: begin
          stop_flag <= stop_flag || stop;
          if (hb_last) begin
            blank_cnt <= '0;
            if (!last_line) y <= y + SIZE_WIDTH'(1);
          end else begin
            blank_cnt <= blank_cnt + SIZE_WIDTH'(1);
          end
        end
        default: begin
          stop_flag <= stop_flag || stop;
          if (vb_last) begin
            blank_cnt <= '0;
            y         <= '0;
            frame_cnt <= frame_next;
            if (finish) stop_flag <= 1'b0;
          end else begin
            blank_cnt <= blank_cnt + SIZE_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (launch) state_next = S_ACTIVE;
      S_ACTIVE: if (line_end) state_next = S_HBLANK;
      S_HBLANK: if (hb_last) state_next = last_line ? S_VBLANK : S_ACTIVE;
      default:  if (vb_last) state_next = finish ? S_IDLE : S_ACTIVE;
    endcase
  end

  // Output values for the next cycle, derived from the current state and position
  always_comb begin
    case (lat_mode)
      2'd0:    pattern = PIXEL_WIDTH'(x);
      2'd1:    pattern = PIXEL_WIDTH'(y);
      2'd2:    pattern = PIXEL_WIDTH'(x) + PIXEL_WIDTH'(y);
      default: pattern = lat_const;
    endcase
    de_n   = (state == S_ACTIVE) && slot_last;
    hs_n   = (state != S_ACTIVE);
    vs_n   = (state == S_ACTIVE) || ((state == S_HBLANK) && !last_line);
    busy_n = (state != S_IDLE);
    done_n = (state == S_VBLANK) && finish;
    do_n   = do_o;
    if (de_n) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        do_n[c*PIXEL_WIDTH +: PIXEL_WIDTH] = pattern + PIXEL_WIDTH'(c);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      do_o   <= '0;
      de_o   <= 1'b0;
      hs_o   <= 1'b1;
      vs_o   <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      do_o   <= do_n;
      de_o   <= de_n;
      hs_o   <= hs_n;
      vs_o   <= vs_n;
      busy_o <= busy_n;
      done_o <= done_n;
    end
  end

endmodule

// File: tb/tb_video_stim_gen.sv
// tb/tb_video_stim_gen.sv - randomized self-checking bench for video_stim_gen
module tb_video_stim_gen;
  localparam int PW = 8;
  localparam int CC = 2;
  localparam int SW = 13;
  localparam int FW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [SW-1:0]     reg_w, reg_h, reg_hblank, reg_vblank;
  logic [3:0]        reg_de_period;
  logic [1:0]        reg_mode;
  logic [PW-1:0]     reg_const;
  logic [FW-1:0]     reg_frame_count;
  logic              start, stop;
  logic [PW*CC-1:0]  do_o;
  logic              de_o, hs_o, vs_o, busy_o, done_o;

  video_stim_gen #(
    .PIXEL_WIDTH(PW), .CHANNEL_COUNT(CC), .SIZE_WIDTH(SW), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .reg_w(reg_w), .reg_h(reg_h), .reg_de_period(reg_de_period),
    .reg_hblank(reg_hblank), .reg_vblank(reg_vblank), .reg_mode(reg_mode),
    .reg_const(reg_const), .reg_frame_count(reg_frame_count), .start(start), .stop(stop),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Latched configuration of the run being modelled
  int cw, ch, cp, chb, cvb, cmode, cconst, cfc;
  logic [15:0] last_do;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h (done,busy,vs,hs,de,do)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit dn, input bit bz, input bit v, input bit h,
                                       input bit d, input logic [15:0] px);
    return {11'b0, dn, bz, v, h, d, px};
  endfunction

  function automatic logic [31:0] observed();
    return {11'b0, done_o, busy_o, vs_o, hs_o, de_o, do_o};
  endfunction

  task automatic randomize_regs();
    reg_w           = SW'($urandom_range(0, 9));
    reg_h           = SW'($urandom_range(0, 5));
    reg_de_period   = 4'($urandom_range(0, 15));
    reg_hblank      = SW'($urandom_range(0, 5));
    reg_vblank      = SW'($urandom_range(0, 5));
    reg_mode        = 2'($urandom_range(0, 3));
    reg_const       = PW'($urandom_range(0, 255));
    reg_frame_count = FW'($urandom_range(0, 3));
  endtask

  // stop_at: -1 none, -2 together with start, else cycle offset from first ACTIVE cycle.
  // abort_at: -1 none, else cycle offset at which rst is pulsed.
  task automatic run(input string tag, input int stop_at, input int abort_at);
    int pe, hbe, vbe, ll, flen, fs, n, k, r, q, yy, xx, pat;
    bit de, hs, vs;
    logic [31:0] exp;
    pe   = (cp == 0) ? 1 : cp;
    hbe  = (chb == 0) ? 1 : chb;
    vbe  = (cvb == 0) ? 1 : cvb;
    ll   = cw * pe + hbe;
    flen = ch * ll + vbe;
    if (stop_at == -2) fs = 1;
    else if (stop_at >= 0) fs = stop_at / flen + 1;
    else fs = 1 << 20;
    n = (cfc != 0 && cfc < fs) ? cfc : fs;
    @(negedge clk);
    reg_w = SW'(cw); reg_h = SW'(ch); reg_de_period = 4'(cp);
    reg_hblank = SW'(chb); reg_vblank = SW'(cvb); reg_mode = 2'(cmode);
    reg_const = PW'(cconst); reg_frame_count = FW'(cfc);
    start = 1'b1;
    stop  = (stop_at == -2);
    for (int j = 0; j <= n * flen + 3; j++) begin
      @(negedge clk);
      if (abort_at >= 0 && j == abort_at + 1) begin
        last_do = '0;
        check_vec({tag, "_rst"}, observed(), pack(0, 0, 0, 1, 0, 16'h0));
        rst = 1'b0;
        break;
      end
      if (j == 0 || j > n * flen) begin
        exp = pack(0, 0, 0, 1, 0, last_do);
      end else begin
        k  = j - 1;
        r  = k % flen;
        de = 0;
        if (r >= ch * ll) begin
          hs = 1; vs = 0;
        end else begin
          yy = r / ll;
          q  = r % ll;
          if (q < cw * pe) begin
            xx = q / pe;
            hs = 0; vs = 1;
            de = ((q % pe) == pe - 1);
            case (cmode)
              0:       pat = xx;
              1:       pat = yy;
              2:       pat = xx + yy;
              default: pat = cconst;
            endcase
            if (de) last_do = {8'((pat + 1) & 255), 8'(pat & 255)};
          end else begin
            hs = 1; vs = (yy != ch - 1);
          end
        end
        exp = pack(j == n * flen, 1, vs, hs, de, last_do);
      end
      check_vec(tag, observed(), exp);
      randomize_regs();
      start = (j < n * flen) ? ($urandom_range(0, 5) == 0) : 1'b0;
      stop  = (j == stop_at);
      if (abort_at >= 0 && j == abort_at) rst = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic set_cfg(input int w, input int h, input int p, input int hb, input int vb,
                         input int mode, input int cnst, input int fc);
    cw = w; ch = h; cp = p; chb = hb; cvb = vb; cmode = mode; cconst = cnst; cfc = fc;
  endtask

  task automatic zero_size(input string tag, input int w, input int h);
    @(negedge clk);
    reg_w = SW'(w); reg_h = SW'(h); reg_frame_count = FW'(1);
    start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      start = 1'b0;
      check_vec(tag, observed(), pack(0, 0, 0, 1, 0, last_do));
    end
  endtask

  initial begin
    int fl, fsel;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    reg_w = '0; reg_h = '0; reg_de_period = '0; reg_hblank = '0; reg_vblank = '0;
    reg_mode = '0; reg_const = '0; reg_frame_count = '0;
    last_do = '0;
    repeat (3) @(negedge clk);
    check_vec("reset", observed(), pack(0, 0, 0, 1, 0, 16'h0));
    rst = 1'b0;

    set_cfg(4, 2, 1, 2, 3, 0, 0, 1);   run("basic_p1", -1, -1);
    set_cfg(4, 2, 3, 2, 3, 0, 0, 1);   run("basic_p3", -1, -1);
    set_cfg(4, 2, 1, 2, 3, 2, 0, 1);   run("diag_2ch", -1, -1);
    set_cfg(300, 1, 1, 1, 1, 0, 0, 1); run("wrap_w300", -1, -1);
    set_cfg(3, 2, 0, 0, 0, 3, 171, 2); run("const_zero_gaps", -1, -1);
    set_cfg(4, 2, 1, 2, 3, 1, 0, 0);   run("stop_frame2", 15 + 7, -1);
    set_cfg(3, 2, 2, 1, 2, 0, 0, 0);   run("start_stop_same", -2, -1);
    set_cfg(2, 1, 1, 1, 1, 2, 0, 0);   run("free_run_wrap", 5 * 5 + 2, -1);
    set_cfg(2, 2, 1, 1, 1, 0, 0, 3);   run("count3", -1, -1);
    set_cfg(5, 2, 2, 2, 2, 0, 0, 1);   run("abort_mid_line", -1, 6);
    set_cfg(4, 2, 1, 2, 3, 0, 0, 1);   run("after_abort", -1, -1);
    zero_size("zero_w", 0, 2);
    zero_size("zero_h", 3, 0);

    for (int t = 0; t < 25; t++) begin
      set_cfg($urandom_range(1, 8), $urandom_range(1, 4), $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 255), $urandom_range(0, 3));
      fl = cw * ((cp == 0) ? 1 : cp) + ((chb == 0) ? 1 : chb);
      fl = ch * fl + ((cvb == 0) ? 1 : cvb);
      fsel = (cfc != 0) ? cfc : 3;
      if (cfc == 0 || $urandom_range(0, 1) == 1) run("rand_stop", $urandom_range(0, fsel * fl - 1), -1);
      else run("rand_count", -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
